board_renderer: RTL

Parametrised board rasteriser for the Othello display path. On a `start` pulse it walks either the whole `BOARD_N`×`BOARD_N` board or one selected cell. For each cell it reads the cell state from the board store and emits one pixel per cycle (`plot`/`x`/`y`/`colour`) to the VGA frame-buffer adapter. Each cell is drawn with a grid border, a cursor highlight, a circular disk and a hint dot. It sits between the game datapath's board register file and the VGA adapter.

---
 rtl/board_renderer_if.sv | 33 +++
 rtl/board_renderer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/board_renderer_if.sv
// Board renderer bus: control request, board-store read port and pixel stream.
interface board_renderer_if #(
  parameter int RW       = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 18
);
  logic                start;
  logic                mode;
  logic [RW-1:0]       sel_row;
  logic [RW-1:0]       sel_col;
  logic [RW-1:0]       cursor_row;
  logic [RW-1:0]       cursor_col;
  logic [RW-1:0]       rd_row;
  logic [RW-1:0]       rd_col;
  logic [1:0]          rd_state;
  logic                plot;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                busy;
  logic                done;

  modport master (
    output start, mode, sel_row, sel_col, cursor_row, cursor_col, rd_state,
    input  rd_row, rd_col, plot, x, y, colour, busy, done
  );

  modport slave (
    input  start, mode, sel_row, sel_col, cursor_row, cursor_col, rd_state,
    output rd_row, rd_col, plot, x, y, colour, busy, done
  );
endinterface

// File: rtl/board_renderer.sv
// Othello board rasteriser: walks the whole board or one cell and streams
// one pixel per cycle (grid border, cursor, disk, hint dot) to the VGA adapter.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read address of current cell on rd_row/rd_col
// LATCH | board store answers; capture state/cursor-hit, emit pixel (0,0)
// DRAW  | emit remaining pixels; final cycle is the tail of the last plot
// DONE  | one-cycle done pulse
module board_renderer #(
  parameter int              BOARD_N    = 8,
  parameter int              CELL_PX    = 14,
  parameter int              X0         = 4,
  parameter int              Y0         = 4,
  parameter int              X_W        = 8,
  parameter int              Y_W        = 7,
  parameter int              COLOUR_W   = 18,
  parameter logic [COLOUR_W-1:0] COL_BG     = 18'h00800,
  parameter logic [COLOUR_W-1:0] COL_GRID   = 18'h00000,
  parameter logic [COLOUR_W-1:0] COL_CURSOR = 18'h3F000,
  parameter logic [COLOUR_W-1:0] COL_BLACK  = 18'h08208,
  parameter logic [COLOUR_W-1:0] COL_WHITE  = 18'h3FFFF,
  parameter logic [COLOUR_W-1:0] COL_HINT   = 18'h3FFC0
) (
  input logic             clock,
  input logic             resetn,
  board_renderer_if.slave bus
);
  localparam int RW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;
  localparam int PW = $clog2(CELL_PX + 1);
  localparam int DW = 2 * PW + 1;
  localparam int XI = X_W + 1;
  localparam int YI = Y_W + 1;
  localparam logic [PW-1:0] C_PX    = PW'(CELL_PX / 2);
  localparam logic [PW-1:0] LAST_PX = PW'(CELL_PX - 1);
  localparam logic [DW-1:0] DISK_R2 = DW'((CELL_PX / 2 - 2) * (CELL_PX / 2 - 2));
  localparam logic [DW-1:0] HINT_R2 = DW'(4);
  localparam logic [RW-1:0] LAST_RC = RW'(BOARD_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_DONE} state_t;

  state_t              state_q;
  logic                mode_q;
  logic [RW-1:0]       row_q, col_q;
  logic [1:0]          cell_q;
  logic                hit_q;
  logic [PW-1:0]       px_q, py_q;
  logic                last_q;
  logic                plot_q, busy_q, done_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;

  logic                sel_ok;
  logic                hit_live;
  logic [PW-1:0]       e_px, e_py, dx, dy;
  logic [1:0]          e_state;
  logic                e_hit;
  logic [DW-1:0]       d2;
  logic [X_W-1:0]      x_d;
  logic [Y_W-1:0]      y_d;
  logic [COLOUR_W-1:0] colour_d;

  assign sel_ok   = ({1'b0, bus.sel_row} < (RW+1)'(BOARD_N)) &&
                    ({1'b0, bus.sel_col} < (RW+1)'(BOARD_N));
  assign hit_live = (row_q == bus.cursor_row) && (col_q == bus.cursor_col);

  // Pixel about to be emitted: in LATCH it is (0,0) using the live board
  // answer, since the latched copy only lands at the same edge.
  always_comb begin
    e_px    = (state_q == S_LATCH) ? '0 : px_q;
    e_py    = (state_q == S_LATCH) ? '0 : py_q;
    e_state = (state_q == S_LATCH) ? bus.rd_state : cell_q;
    e_hit   = (state_q == S_LATCH) ? hit_live : hit_q;
    dx      = (e_px >= C_PX) ? (e_px - C_PX) : (C_PX - e_px);
    dy      = (e_py >= C_PX) ? (e_py - C_PX) : (C_PX - e_py);
    d2      = DW'(dx) * DW'(dx) + DW'(dy) * DW'(dy);
    x_d     = X_W'(XI'(X0) + XI'(col_q) * XI'(CELL_PX) + XI'(e_px));
    y_d     = Y_W'(YI'(Y0) + YI'(row_q) * YI'(CELL_PX) + YI'(e_py));
    colour_d = COL_BG;
    if (e_px == '0 || e_py == '0)
      colour_d = e_hit ? COL_CURSOR : COL_GRID;
    else if (e_state == 2'b01 && d2 <= DISK_R2)
      colour_d = COL_BLACK;
    else if (e_state == 2'b10 && d2 <= DISK_R2)
      colour_d = COL_WHITE;
    else if (e_state == 2'b11 && d2 <= HINT_R2)
      colour_d = COL_HINT;
  end

  // Walk controller with registered pixel outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      cell_q   <= 2'b00;
      hit_q    <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      last_q   <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            busy_q <= 1'b1;
            if (!bus.mode) begin
              row_q   <= '0;
              col_q   <= '0;
              state_q <= S_FETCH;
            end else if (sel_ok) begin
              row_q   <= bus.sel_row;
              col_q   <= bus.sel_col;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          cell_q   <= bus.rd_state;
          hit_q    <= hit_live;
          plot_q   <= 1'b1;
          x_q      <= x_d;
          y_q      <= y_d;
          colour_q <= colour_d;
          px_q     <= PW'(1);
          py_q     <= '0;
          last_q   <= 1'b0;
          state_q  <= S_DRAW;
        end
        S_DRAW: begin
          if (last_q) begin
            if (mode_q || (col_q == LAST_RC && row_q == LAST_RC)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              if (col_q == LAST_RC) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
              end else begin
                col_q <= col_q + RW'(1);
              end
              state_q <= S_FETCH;
            end
          end else begin
            plot_q   <= 1'b1;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            if (px_q == LAST_PX) begin
              px_q <= '0;
              if (py_q == LAST_PX) last_q <= 1'b1;
              else                 py_q   <= py_q + PW'(1);
            end else begin
              px_q <= px_q + PW'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_row = row_q;
  assign bus.rd_col = col_q;
  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
